tv80_blkseq: RTL and testbench
==============================

Name: tv80_blkseq

Overview:
- Write-port sequencer placed directly upstream of the 8x16 register file (pairs BC/DE/HL plus alternate bank).
- Performs the pointer and counter updates for block instructions (LDI/LDD, CPI/CPD, INI/IND/OUTI/OUTD and their repeat forms) as single-cycle read-modify-writes on register-file port A.
- While idle it passes the core's port-A address, data and write enables through unchanged.
- While busy it owns port A.

Parameters:
- ALT_BIT, 2: index of the address bit that selects the alternate register bank.

Ports:
- clk  input  1  system clock; rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cen  input  1  clock enable; shared with the register file.
- start  input  1  request pulse; sampled in IDLE when cen=1.
- mode  input  2  operation: 00 LDx (HL, DE, BC); 01 CPx (HL, BC); 10 INx/OUTx (HL, B); 11 reserved.
- dir  input  1  direction: 0 increments HL/DE, 1 decrements them.
- alt  input  1  bank select, captured at start.
- core_addr_a  input  3  core port-A address.
- core_dih  input  8  core port-A write data, high byte.
- core_dil  input  8  core port-A write data, low byte.
- core_weh  input  1  core port-A write enable, high byte.
- core_wel  input  1  core port-A write enable, low byte.
- doah  input  8  register-file port-A read data, high byte.
- doal  input  8  register-file port-A read data, low byte.
- rf_addr_a  output  3  port-A address to the register file.
- rf_dih  output  8  port-A write data, high byte.
- rf_dil  output  8  port-A write data, low byte.
- rf_weh  output  1  port-A write enable, high byte.
- rf_wel  output  1  port-A write enable, low byte.
- busy  output  1  high while the sequencer owns port A.
- done  output  1  single-cycle completion pulse.
- bc_zero  output  1  registered: last BC result equals 16'h0000.
- b_zero  output  1  registered: last B result equals 8'h00.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - FSM in IDLE.
  - busy=0, done=0, bc_zero=0, b_zero=0.
  - Captured mode, dir and alt cleared to 0.
- Pair indices: BC=0, DE=1, HL=2. rf_addr_a = pair index, with bit ALT_BIT set to the captured alt.
- States: IDLE, S_HL, S_DE, S_BC, S_B. The FSM advances only when cen=1; with cen=0 it and all registered outputs hold.
- Transitions from IDLE on start:
  - mode 00 → S_HL.
  - mode 01 → S_HL.
  - mode 10 → S_HL.
  - mode 11 → stays IDLE, pulses done on the next cen cycle, performs no writes.
- Transitions out of S_HL:
  - mode 00 → S_DE.
  - mode 01 → S_BC.
  - mode 10 → S_B.
- Other transitions:
  - S_DE → S_BC.
  - S_BC → IDLE, with done registered high.
  - S_B → IDLE, with done registered high.
- Write performed in each update state (combinational, same cycle):
  - rf_addr_a selects the pair.
  - {rf_dih, rf_dil} = {doah, doal} ± 1.
  - S_HL and S_DE use +1 when dir=0 and −1 when dir=1.
  - S_BC always uses −1.
  - S_B: rf_dih = doah − 1, rf_weh=1, rf_wel=0, so C is untouched.
  - In the other update states rf_weh=rf_wel=1.
- Arithmetic is modulo 2^16 for pairs and modulo 2^8 for B:
  - 16'hFFFF+1 → 16'h0000.
  - 16'h0000−1 → 16'hFFFF.
  - 8'h00−1 → 8'hFF.
- Flag capture:
  - bc_zero is loaded in S_BC from the 16-bit result.
  - b_zero is loaded in S_B from the 8-bit result.
  - Each flag otherwise holds until the next load or reset.
- busy = (state != IDLE), combinational from the state register.
- Cycle counts from the start cycle (cen held high):
  - LDx: writes in cycles +1, +2, +3; done in +4.
  - CPx and INx/OUTx: writes in +1, +2; done in +3.
- In IDLE all rf_* outputs equal the corresponding core_* inputs, combinationally.
- While busy:
  - Core write enables are suppressed; the core must not issue writes.
  - start is ignored.
  - A start arriving in the same cycle as done is accepted, because the FSM is already in IDLE.
- Reset mid-operation: immediate return to IDLE. Writes already committed remain in the register file. The flags clear.

Decomposition:
- Shared include tv80_blkseq_defs.v holds the state encodings, mode codes (LDX/CPX/IOX/RSV) and pair indices (BC/DE/HL).
- One sub-module, tv80_pair_incdec: a combinational 16-bit ±1 unit with dir input, byte-only option and zero-detect outputs. Instantiated once.

Test Plan:
- LDI, alt=0: HL=4000, DE=5000, BC=0003, mode=00, dir=0 → HL=4001, DE=5001, BC=0002; done at start+4; bc_zero=0.
- LDD wrap, alt=1 bank: HL'=0000, DE'=FFFF, BC'=0001, dir=1 → HL'=FFFF, DE'=FFFE, BC'=0000, bc_zero=1; main bank unchanged.
- CPI: HL=FFFF, BC=0000 → HL=0000, BC=FFFF, bc_zero=0, DE untouched; done at start+3.
- OUTI: HL=1234, BC=0177 → HL=1235, BC=0077 (C kept at 77), b_zero=1.
- cen toggled 0/1 every other cycle during LDx → identical final values; done after 4 enabled cycles. A second start while busy is ignored.
- reset_n asserted in S_DE of LDx → immediately busy=0, done=0, flags 0; HL already updated, DE and BC unchanged; in IDLE the core pass-through write to DE=ABCD lands.

Source files
------------

// File: rtl/tv80_blkseq_pkg.sv
// Shared encodings for the block-instruction write-port sequencer:
// FSM states, operation modes and register-pair indices.
package tv80_blkseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HL   = 3'd1,
        ST_DE   = 3'd2,
        ST_BC   = 3'd3,
        ST_B    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_LDX = 2'b00,
        MODE_CPX = 2'b01,
        MODE_IOX = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    localparam logic [1:0] PAIR_BC = 2'd0;
    localparam logic [1:0] PAIR_DE = 2'd1;
    localparam logic [1:0] PAIR_HL = 2'd2;

    // Pair index in the low bits, bank select forced onto alt_bit.
    function automatic logic [2:0] pair_addr(input logic [1:0] pair,
                                             input logic       alt,
                                             input int         alt_bit);
        logic [2:0] a;
        a          = {1'b0, pair};
        a[alt_bit] = alt;
        return a;
    endfunction

endpackage

// File: rtl/tv80_pair_incdec.sv
// Combinational 16-bit +/-1 unit; byte_only adjusts the high byte alone
// and passes the low byte through. Zero flags reflect the result.
module tv80_pair_incdec (
    input  logic [15:0] din_i,
    input  logic        dec_i,
    input  logic        byte_only_i,
    output logic [15:0] dout_o,
    output logic        zero16_o,
    output logic        zero8_o
);

    logic [15:0] sum16;
    logic [7:0]  sum8;

    always_comb begin
        sum16 = din_i + (dec_i ? 16'hFFFF : 16'h0001);
        sum8  = din_i[15:8] + (dec_i ? 8'hFF : 8'h01);
        dout_o = byte_only_i ? {sum8, din_i[7:0]} : sum16;
    end

    assign zero16_o = (dout_o == 16'h0000);
    assign zero8_o  = (dout_o[15:8] == 8'h00);

endmodule

// File: rtl/tv80_blkseq.sv
// Port-A write sequencer for Z80 block instructions: passes core writes through
// while idle and performs HL/DE/BC/B read-modify-writes while busy.
module tv80_blkseq
    import tv80_blkseq_pkg::*;
#(
    parameter int ALT_BIT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       dir,
    input  logic       alt,
    input  logic [2:0] core_addr_a,
    input  logic [7:0] core_dih,
    input  logic [7:0] core_dil,
    input  logic       core_weh,
    input  logic       core_wel,
    input  logic [7:0] doah,
    input  logic [7:0] doal,
    output logic [2:0] rf_addr_a,
    output logic [7:0] rf_dih,
    output logic [7:0] rf_dil,
    output logic       rf_weh,
    output logic       rf_wel,
    output logic       busy,
    output logic       done,
    output logic       bc_zero,
    output logic       b_zero
);

    state_e state_q;
    mode_e  mode_q;
    logic   dir_q, alt_q;
    logic   done_q, bc_zero_q, b_zero_q;

    logic [1:0]  pair_sel;
    logic        dec_sel, byte_sel;
    logic [15:0] upd;
    logic        upd_z16, upd_z8;

    // Per-state operand selection for the shared +/-1 unit.
    always_comb begin
        pair_sel = PAIR_HL;
        dec_sel  = dir_q;
        byte_sel = 1'b0;
        case (state_q)
            ST_HL: pair_sel = PAIR_HL;
            ST_DE: pair_sel = PAIR_DE;
            ST_BC: begin
                pair_sel = PAIR_BC;
                dec_sel  = 1'b1;
            end
            ST_B: begin
                pair_sel = PAIR_BC;
                dec_sel  = 1'b1;
                byte_sel = 1'b1;
            end
            default: ;
        endcase
    end

    tv80_pair_incdec u_incdec (
        .din_i       ({doah, doal}),
        .dec_i       (dec_sel),
        .byte_only_i (byte_sel),
        .dout_o      (upd),
        .zero16_o    (upd_z16),
        .zero8_o     (upd_z8)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_LDX;
            dir_q     <= 1'b0;
            alt_q     <= 1'b0;
            done_q    <= 1'b0;
            bc_zero_q <= 1'b0;
            b_zero_q  <= 1'b0;
        end else if (cen) begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode_e'(mode);
                        dir_q  <= dir;
                        alt_q  <= alt;
                        // Reserved mode completes immediately with no writes.
                        if (mode_e'(mode) == MODE_RSV) done_q  <= 1'b1;
                        else                           state_q <= ST_HL;
                    end
                end
                ST_HL: begin
                    case (mode_q)
                        MODE_LDX: state_q <= ST_DE;
                        MODE_CPX: state_q <= ST_BC;
                        MODE_IOX: state_q <= ST_B;
                        default: begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    endcase
                end
                ST_DE: state_q <= ST_BC;
                ST_BC: begin
                    state_q   <= ST_IDLE;
                    done_q    <= 1'b1;
                    bc_zero_q <= upd_z16;
                end
                ST_B: begin
                    state_q  <= ST_IDLE;
                    done_q   <= 1'b1;
                    b_zero_q <= upd_z8;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        rf_addr_a = core_addr_a;
        rf_dih    = core_dih;
        rf_dil    = core_dil;
        rf_weh    = core_weh;
        rf_wel    = core_wel;
        if (busy) begin
            rf_addr_a = pair_addr(pair_sel, alt_q, ALT_BIT);
            rf_dih    = upd[15:8];
            rf_dil    = upd[7:0];
            rf_weh    = 1'b1;
            rf_wel    = ~byte_sel;
        end
    end

    assign done    = done_q;
    assign bc_zero = bc_zero_q;
    assign b_zero  = b_zero_q;

endmodule

// File: tb/tb_tv80_blkseq.sv
// Bench for tv80_blkseq: register-file harness, step-queue reference model
// checked every cycle, and directed block-instruction scenarios.
module tb_tv80_blkseq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cen = 1'b1, start = 1'b0, dir = 1'b0, alt = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] core_addr_a = 3'd0;
    logic [7:0] core_dih = 8'h00, core_dil = 8'h00;
    logic       core_weh = 1'b0, core_wel = 1'b0;
    logic [7:0] doah, doal;
    logic [2:0] rf_addr_a;
    logic [7:0] rf_dih, rf_dil;
    logic       rf_weh, rf_wel, busy, done, bc_zero, b_zero;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    tv80_blkseq #(.ALT_BIT(2)) dut (
        .clk(clk), .reset_n(reset_n), .cen(cen), .start(start), .mode(mode),
        .dir(dir), .alt(alt), .core_addr_a(core_addr_a), .core_dih(core_dih),
        .core_dil(core_dil), .core_weh(core_weh), .core_wel(core_wel),
        .doah(doah), .doal(doal), .rf_addr_a(rf_addr_a), .rf_dih(rf_dih),
        .rf_dil(rf_dil), .rf_weh(rf_weh), .rf_wel(rf_wel), .busy(busy),
        .done(done), .bc_zero(bc_zero), .b_zero(b_zero)
    );

    always #5 clk = ~clk;

    // Register-file harness: async read, byte-enabled write gated by cen.
    logic [15:0] rf_mem [0:7] = '{default: 16'h0000};
    assign doah = rf_mem[rf_addr_a][15:8];
    assign doal = rf_mem[rf_addr_a][7:0];
    always @(posedge clk) begin
        if (cen && rf_weh) rf_mem[rf_addr_a][15:8] <= rf_dih;
        if (cen && rf_wel) rf_mem[rf_addr_a][7:0]  <= rf_dil;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation becomes a queue of register
    // writes, one retired per enabled cycle; done follows the last one.
    typedef struct {
        logic [2:0]  addr;
        logic [15:0] val;
        logic        hi_only;
        logic [1:0]  flag;   // 0 none, 1 BC zero, 2 B zero
    } step_t;

    step_t       q[$];
    logic [15:0] exp_rf [0:7] = '{default: 16'h0000};
    logic        m_done = 1'b0, m_bcz = 1'b0, m_bz = 1'b0;

    task automatic model_step();
        step_t s;
        logic [2:0]  bk;
        logic [15:0] d;
        logic        nd;
        if (!reset_n) begin
            q.delete();
            m_done = 1'b0; m_bcz = 1'b0; m_bz = 1'b0;
        end else if (cen) begin
            nd = 1'b0;
            if (q.size() > 0) begin
                s = q.pop_front();
                if (s.hi_only) exp_rf[s.addr][15:8] = s.val[15:8];
                else           exp_rf[s.addr]       = s.val;
                if (s.flag == 2'd1) m_bcz = (s.val == 16'h0000);
                if (s.flag == 2'd2) m_bz  = (s.val[15:8] == 8'h00);
                if (q.size() == 0) nd = 1'b1;
            end else begin
                if (core_weh) exp_rf[core_addr_a][15:8] = core_dih;
                if (core_wel) exp_rf[core_addr_a][7:0]  = core_dil;
                if (start) begin
                    bk = alt ? 3'd4 : 3'd0;
                    d  = dir ? 16'hFFFF : 16'h0001;
                    case (mode)
                        2'b00: begin
                            q.push_back('{bk + 3'd2, exp_rf[bk + 3'd2] + d, 1'b0, 2'd0});
                            q.push_back('{bk + 3'd1, exp_rf[bk + 3'd1] + d, 1'b0, 2'd0});
                            q.push_back('{bk, exp_rf[bk] - 16'd1, 1'b0, 2'd1});
                        end
                        2'b01: begin
                            q.push_back('{bk + 3'd2, exp_rf[bk + 3'd2] + d, 1'b0, 2'd0});
                            q.push_back('{bk, exp_rf[bk] - 16'd1, 1'b0, 2'd1});
                        end
                        2'b10: begin
                            q.push_back('{bk + 3'd2, exp_rf[bk + 3'd2] + d, 1'b0, 2'd0});
                            q.push_back('{bk, {exp_rf[bk][15:8] - 8'd1, exp_rf[bk][7:0]}, 1'b1, 2'd2});
                        end
                        default: nd = 1'b1;
                    endcase
                end
            end
            m_done = nd;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("bc_zero", {31'b0, bc_zero}, {31'b0, m_bcz});
            chk("b_zero", {31'b0, b_zero}, {31'b0, m_bz});
            if (q.size() > 0)
                chk("rf_port", {11'b0, rf_addr_a, rf_dih, rf_dil, rf_weh, rf_wel},
                    {11'b0, q[0].addr, q[0].val, 1'b1, ~q[0].hi_only});
            else
                chk("passthru", {11'b0, rf_addr_a, rf_dih, rf_dil, rf_weh, rf_wel},
                    {11'b0, core_addr_a, core_dih, core_dil, core_weh, core_wel});
            for (int i = 0; i < 8; i++) chk($sformatf("rf[%0d]", i), {16'b0, rf_mem[i]}, {16'b0, exp_rf[i]});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        core_addr_a = a; core_dih = v[15:8]; core_dil = v[7:0];
        core_weh = 1'b1; core_wel = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        core_weh = 1'b0; core_wel = 1'b0;
    endtask

    // Returns the number of enabled edges from start until done is seen.
    task automatic run_op(input logic [1:0] m, input logic d, input logic a,
                          input bit tog, input bit ign, output int n);
        int g;
        bit c;
        mode = m; dir = d; alt = a; cen = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 1; g = 0;
        while (done !== 1'b1 && g < 40) begin
            if (tog) cen = ~cen;
            start = ign && (n == 2);
            if (start) mode = 2'b01;
            c = cen;
            @(posedge clk); #1;
            if (c) n++;
            g++;
        end
        start = 1'b0; cen = 1'b1;
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_flags", {30'b0, bc_zero, b_zero}, 32'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // LDI, main bank
        wr(3'd2, 16'h4000); wr(3'd1, 16'h5000); wr(3'd0, 16'h0003);
        run_op(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("ldi_lat", n, 32'd4);
        chk("ldi_hl", {16'b0, rf_mem[2]}, 32'h4001);
        chk("ldi_de", {16'b0, rf_mem[1]}, 32'h5001);
        chk("ldi_bc", {16'b0, rf_mem[0]}, 32'h0002);
        chk("ldi_bcz", {31'b0, bc_zero}, 32'd0);

        // LDD with wrap, alternate bank
        wr(3'd6, 16'h0000); wr(3'd5, 16'hFFFF); wr(3'd4, 16'h0001);
        run_op(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, n);
        chk("ldd_lat", n, 32'd4);
        chk("ldd_hl", {16'b0, rf_mem[6]}, 32'hFFFF);
        chk("ldd_de", {16'b0, rf_mem[5]}, 32'hFFFE);
        chk("ldd_bc", {16'b0, rf_mem[4]}, 32'h0000);
        chk("ldd_bcz", {31'b0, bc_zero}, 32'd1);
        chk("ldd_main_hl", {16'b0, rf_mem[2]}, 32'h4001);

        // CPI with wrap both ways
        wr(3'd2, 16'hFFFF); wr(3'd0, 16'h0000);
        run_op(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("cpi_lat", n, 32'd3);
        chk("cpi_hl", {16'b0, rf_mem[2]}, 32'h0000);
        chk("cpi_bc", {16'b0, rf_mem[0]}, 32'hFFFF);
        chk("cpi_de", {16'b0, rf_mem[1]}, 32'h5001);
        chk("cpi_bcz", {31'b0, bc_zero}, 32'd0);

        // OUTI: B decremented, C preserved
        wr(3'd2, 16'h1234); wr(3'd0, 16'h0177);
        run_op(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("outi_lat", n, 32'd3);
        chk("outi_hl", {16'b0, rf_mem[2]}, 32'h1235);
        chk("outi_bc", {16'b0, rf_mem[0]}, 32'h0077);
        chk("outi_bz", {31'b0, b_zero}, 32'd1);

        // Reserved mode: done next cycle, no writes
        run_op(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, n);
        chk("rsv_lat", n, 32'd1);
        chk("rsv_hl", {16'b0, rf_mem[2]}, 32'h1235);

        // LDI with cen toggling and a stray start while busy
        wr(3'd2, 16'h4000); wr(3'd1, 16'h5000); wr(3'd0, 16'h0003);
        run_op(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, n);
        chk("cen_lat", n, 32'd4);
        chk("cen_hl", {16'b0, rf_mem[2]}, 32'h4001);
        chk("cen_de", {16'b0, rf_mem[1]}, 32'h5001);
        chk("cen_bc", {16'b0, rf_mem[0]}, 32'h0002);
        @(posedge clk); #1;
        chk("cen_idle", {31'b0, busy}, 32'd0);

        // Reset in S_DE of LDI
        wr(3'd2, 16'h4000); wr(3'd1, 16'h5000); wr(3'd0, 16'h0003);
        mode = 2'b00; dir = 1'b0; alt = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_flags", {30'b0, bc_zero, b_zero}, 32'd0);
        chk("mid_rst_hl", {16'b0, rf_mem[2]}, 32'h4001);
        chk("mid_rst_de", {16'b0, rf_mem[1]}, 32'h5000);
        chk("mid_rst_bc", {16'b0, rf_mem[0]}, 32'h0003);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wr(3'd1, 16'hABCD);
        chk("core_de", {16'b0, rf_mem[1]}, 32'hABCD);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
